vga_cell_mem_arbiter: RTL and testbench

- Shares one single-port synchronous playfield RAM (1-cycle read latency) between two masters:
  - the VGA display fetch path, driven by the h/v counters of the sync generator;
  - the Tetris game engine, through a req/gnt port.
- Display fetches are time-critical and always win. The game engine gets every other RAM cycle.
- Fetched cell colour is presented to the pixel mux, aligned to the cell boundary.

---
 rtl/vga_cell_mem_arbiter.sv | 134 +++++++++++++
 tb/tb_vga_cell_mem_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_cell_mem_arbiter.sv
`default_nettype none
// ==========================================================================
// vga_cell_mem_arbiter: display fetch / game engine arbiter for the playfield RAM.
// Optional macro VBLANK_ONLY_WR_EN limits engine writes to vertical blanking. Rev 1.0
// ==========================================================================
module vga_cell_mem_arbiter #(
  parameter int H_ACT_START = 144,
  parameter int H_ACT_END   = 784,
  parameter int V_ACT_START = 34,
  parameter int V_ACT_END   = 514,
  parameter int CELL_SHIFT  = 4,
  parameter int GRID_COLS   = 40,
  parameter int ADDR_W      = 11,
  parameter int DATA_W      = 4,
  parameter int FETCH_LEAD  = 3
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [9:0]        h_cnt_i,
  input  logic [9:0]        v_cnt_i,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_we_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_gnt_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_rvalid_o,
  output logic [DATA_W-1:0] cell_color_o,
  output logic              cell_valid_o
);

  localparam logic [9:0] SLOT_H_LO = 10'(H_ACT_START - FETCH_LEAD);
  localparam logic [9:0] SLOT_H_HI = 10'(H_ACT_END - FETCH_LEAD);
  localparam logic [9:0] ACT_H_LO  = 10'(H_ACT_START);
  localparam logic [9:0] ACT_H_HI  = 10'(H_ACT_END);
  localparam logic [9:0] ACT_V_LO  = 10'(V_ACT_START);
  localparam logic [9:0] ACT_V_HI  = 10'(V_ACT_END);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DISP = 2'd1,
    CPU  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic                ram_we_q, ram_we_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
  logic                disp_rd_q;
  logic                cpu_rd_q;
  logic [DATA_W-1:0]   cpu_rdata_q;
  logic                cpu_rvalid_q;
  logic [DATA_W-1:0]   cell_color_q;

  logic [10:0]         h_off, v_off, row, col;
  logic [ADDR_W-1:0]   disp_addr;
  logic                v_act, h_win, slot, cpu_ok;

  // h_off is the pixel offset of the cell boundary FETCH_LEAD clocks ahead
  assign h_off = {1'b0, h_cnt_i} + 11'(FETCH_LEAD) - 11'(H_ACT_START);
  assign v_off = {1'b0, v_cnt_i} - 11'(V_ACT_START);
  assign row   = v_off >> CELL_SHIFT;
  assign col   = h_off >> CELL_SHIFT;
  assign disp_addr = ADDR_W'(32'(row) * 32'(GRID_COLS) + 32'(col));

  assign v_act = (v_cnt_i >= ACT_V_LO) && (v_cnt_i < ACT_V_HI);
  assign h_win = (h_cnt_i >= SLOT_H_LO) && (h_cnt_i < SLOT_H_HI);
  assign slot  = v_act && h_win && (h_off[CELL_SHIFT-1:0] == '0);

  assign cell_valid_o = v_act && (h_cnt_i >= ACT_H_LO) && (h_cnt_i < ACT_H_HI);

  always_comb begin
    cpu_ok = cpu_req_i && !cpu_gnt_o;
`ifdef VBLANK_ONLY_WR_EN
    if (cpu_we_i && v_act) cpu_ok = 1'b0;
`else
`endif
  end

  always_comb begin
    state_d     = IDLE;
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_wdata_d = ram_wdata_q;
    if (slot) begin
      state_d    = DISP;
      ram_addr_d = disp_addr;
    end else if (cpu_ok) begin
      state_d     = CPU;
      ram_addr_d  = cpu_addr_i;
      ram_we_d    = cpu_we_i;
      ram_wdata_d = cpu_wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      ram_addr_q   <= '0;
      ram_we_q     <= 1'b0;
      ram_wdata_q  <= '0;
      disp_rd_q    <= 1'b0;
      cpu_rd_q     <= 1'b0;
      cpu_rdata_q  <= '0;
      cpu_rvalid_q <= 1'b0;
      cell_color_q <= '0;
    end else begin
      state_q      <= state_d;
      ram_addr_q   <= ram_addr_d;
      ram_we_q     <= ram_we_d;
      ram_wdata_q  <= ram_wdata_d;
      // RAM data returns one cycle after the address cycle
      disp_rd_q    <= (state_q == DISP);
      cpu_rd_q     <= (state_q == CPU) && !ram_we_q;
      cpu_rvalid_q <= cpu_rd_q;
      if (cpu_rd_q)  cpu_rdata_q  <= ram_rdata_i;
      if (disp_rd_q) cell_color_q <= ram_rdata_i;
    end
  end

  assign ram_addr_o   = ram_addr_q;
  assign ram_we_o     = ram_we_q;
  assign ram_wdata_o  = ram_wdata_q;
  assign cpu_gnt_o    = (state_q == CPU);
  assign cpu_rdata_o  = cpu_rdata_q;
  assign cpu_rvalid_o = cpu_rvalid_q;
  assign cell_color_o = cell_color_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_cell_mem_arbiter.sv
`default_nettype none
// tb_vga_cell_mem_arbiter: directed self-checking bench with a behavioural single-port RAM.
module tb_vga_cell_mem_arbiter;

  logic        clk_i;
  logic        reset_i;
  logic [9:0]  h_cnt_i, v_cnt_i;
  logic [10:0] ram_addr_o;
  logic        ram_we_o;
  logic [3:0]  ram_wdata_o;
  logic [3:0]  ram_rdata_i;
  logic        cpu_req_i, cpu_we_i;
  logic [10:0] cpu_addr_i;
  logic [3:0]  cpu_wdata_i;
  logic        cpu_gnt_o;
  logic [3:0]  cpu_rdata_o;
  logic        cpu_rvalid_o;
  logic [3:0]  cell_color_o;
  logic        cell_valid_o;

  int n_checks;
  int n_errors;

  logic        rst_nx, req_nx, we_nx;
  logic [10:0] addr_nx;
  logic [3:0]  wd_nx;
  logic        load, poke;
  logic        p4_we;
  logic        exp_gnt;
  logic [3:0]  mem [0:2047];

  vga_cell_mem_arbiter dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .h_cnt_i      (h_cnt_i),
    .v_cnt_i      (v_cnt_i),
    .ram_addr_o   (ram_addr_o),
    .ram_we_o     (ram_we_o),
    .ram_wdata_o  (ram_wdata_o),
    .ram_rdata_i  (ram_rdata_i),
    .cpu_req_i    (cpu_req_i),
    .cpu_we_i     (cpu_we_i),
    .cpu_addr_i   (cpu_addr_i),
    .cpu_wdata_i  (cpu_wdata_i),
    .cpu_gnt_o    (cpu_gnt_o),
    .cpu_rdata_o  (cpu_rdata_o),
    .cpu_rvalid_o (cpu_rvalid_o),
    .cell_color_o (cell_color_o),
    .cell_valid_o (cell_valid_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Single-port RAM, 1-cycle read latency; preload is addr mod 16
  always @(posedge clk_i) begin
    if (load) begin
      for (int i = 0; i < 2048; i++) mem[i] <= 4'(i % 16);
    end else begin
      if (poke) mem[5] <= 4'd9;
      if (ram_we_o) mem[ram_addr_o] <= ram_wdata_o;
    end
    ram_rdata_i <= mem[ram_addr_o];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock: apply inputs just after the edge, return mid-cycle for sampling
  task automatic go(input int v, input int h);
    @(posedge clk_i);
    #1;
    reset_i     = rst_nx;
    v_cnt_i     = 10'(v);
    h_cnt_i     = 10'(h);
    cpu_req_i   = req_nx;
    cpu_we_i    = we_nx;
    cpu_addr_i  = addr_nx;
    cpu_wdata_i = wd_nx;
    @(negedge clk_i);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_i = 1'b1; rst_nx = 1'b1;
    h_cnt_i = '0; v_cnt_i = 10'd20;
    cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_wdata_i = '0;
    req_nx = 1'b0; we_nx = 1'b0; addr_nx = '0; wd_nx = '0;
    load = 1'b1; poke = 1'b0;
`ifdef VBLANK_ONLY_WR_EN
    p4_we = 1'b0;
`else
    p4_we = 1'b1;
`endif

    // Reset state
    go(20, 0);
    load = 1'b0;
    go(20, 1);
    check_eq("rst_addr",  32'(ram_addr_o),   0);
    check_eq("rst_we",    32'(ram_we_o),     0);
    check_eq("rst_gnt",   32'(cpu_gnt_o),    0);
    check_eq("rst_color", 32'(cell_color_o), 0);
    rst_nx = 1'b0;
    go(20, 2);

    // Row 0 display fetch across a full line
    for (int h = 130; h <= 790; h++) begin
      go(34, h);
      if (h >= 142 && h <= 766 && (h - 142) % 16 == 0) begin
        check_eq($sformatf("fetch_addr h=%0d", h), 32'(ram_addr_o), 32'((h - 142) / 16));
        check_eq($sformatf("fetch_we h=%0d", h), 32'(ram_we_o), 0);
      end
      if (h >= 144)
        check_eq($sformatf("color h=%0d", h), 32'(cell_color_o),
                 32'((((h < 784) ? h : 783) - 144) / 16 % 16));
      check_eq($sformatf("valid h=%0d", h), 32'(cell_valid_o), 32'(h >= 144 && h < 784));
    end

    // Row 1 first slot and row 29 last slot
    go(50, 140); go(50, 141); go(50, 142);
    check_eq("row1_addr", 32'(ram_addr_o), 40);
    go(513, 764); go(513, 765); go(513, 766);
    check_eq("row29_addr", 32'(ram_addr_o), 1199);
    check_eq("row29_valid", 32'(cell_valid_o), 1);

    // Engine read of addr 5 colliding with slot 141
    poke = 1'b1;
    go(34, 138);
    poke = 1'b0;
    go(34, 139); go(34, 140);
    req_nx = 1'b1; we_nx = 1'b0; addr_nx = 11'd5;
    go(34, 141);
    check_eq("rd_gnt141", 32'(cpu_gnt_o), 0);
    go(34, 142);
    check_eq("rd_gnt142", 32'(cpu_gnt_o), 0);
    check_eq("rd_disp_addr", 32'(ram_addr_o), 0);
    go(34, 143);
    check_eq("rd_gnt143", 32'(cpu_gnt_o), 1);
    check_eq("rd_addr", 32'(ram_addr_o), 5);
    check_eq("rd_we", 32'(ram_we_o), 0);
    req_nx = 1'b0;
    go(34, 144);
    check_eq("rd_gnt144", 32'(cpu_gnt_o), 0);
    check_eq("rd_color144", 32'(cell_color_o), 0);
    check_eq("rd_rvalid144", 32'(cpu_rvalid_o), 0);
    go(34, 145);
    check_eq("rd_rvalid145", 32'(cpu_rvalid_o), 1);
    check_eq("rd_rdata", 32'(cpu_rdata_o), 9);
    go(34, 146);
    check_eq("rd_rvalid146", 32'(cpu_rvalid_o), 0);
    for (int h = 147; h <= 230; h++) begin
      go(34, h);
      if (h == 158) check_eq("rd_fetch158", 32'(ram_addr_o), 1);
      if (h == 160) check_eq("rd_color160", 32'(cell_color_o), 1);
      if (h == 224) check_eq("rd_color224", 32'(cell_color_o), 9);
    end

    // Held engine requests: grant spacing and display priority around slots 141/157
    for (int h = 130; h <= 136; h++) go(34, h);
    req_nx = 1'b1; we_nx = p4_we; addr_nx = 11'd2047; wd_nx = 4'd10;
    for (int h = 137; h <= 160; h++) begin
      go(34, h);
      exp_gnt = (h == 138 || h == 140 || (h >= 143 && h % 2 == 1));
      check_eq($sformatf("held_gnt h=%0d", h), 32'(cpu_gnt_o), 32'(exp_gnt));
      check_eq($sformatf("held_we h=%0d", h), 32'(ram_we_o), 32'(exp_gnt && p4_we));
      if (h == 142) check_eq("held_disp142", 32'(ram_addr_o), 0);
      if (h == 158) check_eq("held_disp158", 32'(ram_addr_o), 1);
    end
    req_nx = 1'b0;
    go(34, 161); go(34, 162);

    // Write request in the active area
    go(100, 0);
    req_nx = 1'b1; we_nx = 1'b1; addr_nx = 11'd2046; wd_nx = 4'd3;
`ifdef VBLANK_ONLY_WR_EN
    for (int h = 1; h <= 10; h++) begin
      go(100, h);
      check_eq($sformatf("vb_hold h=%0d", h), 32'(cpu_gnt_o), 0);
    end
    go(514, 0);
    check_eq("vb_gnt0", 32'(cpu_gnt_o), 0);
    check_eq("vb_valid", 32'(cell_valid_o), 0);
    go(514, 1);
    check_eq("vb_gnt1", 32'(cpu_gnt_o), 1);
    check_eq("vb_we", 32'(ram_we_o), 1);
    req_nx = 1'b0;
    go(514, 2);
`else
    go(100, 1);
    check_eq("wr_gnt1", 32'(cpu_gnt_o), 0);
    go(100, 2);
    check_eq("wr_gnt2", 32'(cpu_gnt_o), 1);
    check_eq("wr_we", 32'(ram_we_o), 1);
    check_eq("wr_addr", 32'(ram_addr_o), 2046);
    req_nx = 1'b0;
    go(100, 3);
`endif
    // Read in the active area is granted under either build
    req_nx = 1'b1; we_nx = 1'b0; addr_nx = 11'd5;
    go(100, 3);
    check_eq("ar_gnt3", 32'(cpu_gnt_o), 0);
    go(100, 4);
    check_eq("ar_gnt4", 32'(cpu_gnt_o), 1);
    req_nx = 1'b0;
    go(100, 5);
    go(100, 6);
    check_eq("ar_rvalid", 32'(cpu_rvalid_o), 1);
    check_eq("ar_rdata", 32'(cpu_rdata_o), 9);

    // Asynchronous reset mid-line with a pending request
    go(20, 100);
    #2;
    reset_i = 1'b1; rst_nx = 1'b1;
    #1;
    check_eq("arst_addr",   32'(ram_addr_o),   0);
    check_eq("arst_we",     32'(ram_we_o),     0);
    check_eq("arst_wdata",  32'(ram_wdata_o),  0);
    check_eq("arst_gnt",    32'(cpu_gnt_o),    0);
    check_eq("arst_rdata",  32'(cpu_rdata_o),  0);
    check_eq("arst_rvalid", 32'(cpu_rvalid_o), 0);
    check_eq("arst_color",  32'(cell_color_o), 0);
    req_nx = 1'b1; we_nx = 1'b0; addr_nx = 11'd7;
    for (int h = 101; h <= 104; h++) begin
      go(20, h);
      check_eq($sformatf("arst_hold h=%0d", h), 32'(cpu_gnt_o), 0);
    end
    rst_nx = 1'b0;
    go(20, 105);
    check_eq("rel_gnt105", 32'(cpu_gnt_o), 0);
    go(20, 106);
    check_eq("rel_gnt106", 32'(cpu_gnt_o), 1);
    check_eq("rel_addr", 32'(ram_addr_o), 7);
    req_nx = 1'b0;
    go(20, 107);
    check_eq("rel_gnt107", 32'(cpu_gnt_o), 0);
    go(20, 108);
    check_eq("rel_rvalid", 32'(cpu_rvalid_o), 1);
    check_eq("rel_rdata", 32'(cpu_rdata_o), 7);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
